halt_result_checker: RTL and testbench

Synthesizable, parametrised successor to the simulation-only end-of-program check. It watches the CPU halt indication, then reads a programmable list of memory words through a single read port and compares each against an expected value. It reports pass/fail, mismatch count, the first failing entry and an optional timeout. It sits beside the CPU and memory in the top level, and drives LEDs and HEX displays on the board.

---
 rtl/halt_result_checker.sv | 161 ++++++++++++++++
 tb/tb_halt_result_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/halt_result_checker.sv
// halt_result_checker: after CPU halt, reads a table of memory words and compares each to its expected value; optional timeout via HALT_CHECKER_TIMEOUT_EN
module halt_result_checker #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int NUM_CHECKS = 8,
    parameter int TIMEOUT_W = 24,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    input  logic              halt,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IDX_W:0]    fail_count,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [DATA_W-1:0] first_fail_data,
    output logic              timeout
);
    typedef enum logic [2:0] {IDLE, ARMED, ISSUE, COMPARE, DONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [IDX_W:0]      fail_count_q, fail_count_d;
    logic [IDX_W-1:0]    ffi_q, ffi_d;
    logic [DATA_W-1:0]   ffd_q, ffd_d;
    logic                timeout_q, timeout_d;
    logic                rd_en;
    logic                last;
    logic                tbl_valid_q [NUM_CHECKS];
    logic                tbl_valid_d [NUM_CHECKS];
    logic [ADDR_W-1:0]   tbl_addr_q [NUM_CHECKS];
    logic [ADDR_W-1:0]   tbl_addr_d [NUM_CHECKS];
    logic [DATA_W-1:0]   tbl_exp_q [NUM_CHECKS];
    logic [DATA_W-1:0]   tbl_exp_d [NUM_CHECKS];

`ifdef HALT_CHECKER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 expired;

    // Cycles spent in ARMED; restarts from zero on every entry to ARMED
    always_comb cnt_d = (state_q == ARMED) ? cnt_q + 1'b1 : '0;

    // Timeout counter register
    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;

    assign expired = (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_W'(TIMEOUT_CYCLES);
`endif

    assign last = (idx_q == IDX_W'(NUM_CHECKS - 1));

    // Next-state, table update, scan sequencing and result accumulation
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        mem_addr_d = mem_addr_q;
        fail_count_d = fail_count_q;
        ffi_d = ffi_q;
        ffd_d = ffd_q;
        timeout_d = timeout_q;
        tbl_valid_d = tbl_valid_q;
        tbl_addr_d = tbl_addr_q;
        tbl_exp_d = tbl_exp_q;
        rd_en = 1'b0;
        if ((state_q == IDLE || state_q == DONE) && start) begin
            state_d = ARMED;
            fail_count_d = '0;
            ffi_d = '0;
            ffd_d = '0;
            timeout_d = 1'b0;
        end
        case (state_q)
            IDLE: if (cfg_we) begin
                tbl_valid_d[cfg_idx] = 1'b1;
                tbl_addr_d[cfg_idx] = cfg_addr;
                tbl_exp_d[cfg_idx] = cfg_data;
            end
            ARMED: if (halt) begin
                state_d = ISSUE;
                idx_d = '0;
            end
`ifdef HALT_CHECKER_TIMEOUT_EN
            else if (expired) begin
                state_d = DONE;
                timeout_d = 1'b1;
            end
`endif
            ISSUE: if (tbl_valid_q[idx_q]) begin
                rd_en = 1'b1;
                mem_addr_d = tbl_addr_q[idx_q];
                state_d = COMPARE;
            end else begin
                state_d = last ? DONE : ISSUE;
                idx_d = last ? idx_q : idx_q + 1'b1;
            end
            COMPARE: begin
                if (mem_rdata != tbl_exp_q[idx_q]) begin
                    fail_count_d = fail_count_q + 1'b1;
                    ffi_d = (fail_count_q == '0) ? idx_q : ffi_q;
                    ffd_d = (fail_count_q == '0) ? mem_rdata : ffd_q;
                end
                state_d = last ? DONE : ISSUE;
                idx_d = last ? idx_q : idx_q + 1'b1;
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
    end

    // Control and result registers; reset also invalidates the whole table
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q <= '0;
            mem_addr_q <= '0;
            fail_count_q <= '0;
            ffi_q <= '0;
            ffd_q <= '0;
            timeout_q <= 1'b0;
            tbl_valid_q <= '{default: 1'b0};
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            mem_addr_q <= mem_addr_d;
            fail_count_q <= fail_count_d;
            ffi_q <= ffi_d;
            ffd_q <= ffd_d;
            timeout_q <= timeout_d;
            tbl_valid_q <= tbl_valid_d;
        end
    end

    // Table payload needs no reset; the valid bits gate its use
    always_ff @(posedge clk) begin
        tbl_addr_q <= tbl_addr_d;
        tbl_exp_q <= tbl_exp_d;
    end

    assign mem_rd_en = rd_en;
    assign mem_addr = mem_addr_d;
    assign busy = (state_q == ARMED) || (state_q == ISSUE) || (state_q == COMPARE);
    assign done = (state_q == DONE);
    assign pass = done && !timeout_q && (fail_count_q == '0);
    assign fail_count = fail_count_q;
    assign first_fail_idx = ffi_q;
    assign first_fail_data = ffd_q;
    assign timeout = timeout_q;
endmodule

// File: tb/tb_halt_result_checker.sv
// tb_halt_result_checker: directed scoreboard bench for halt_result_checker (NUM_CHECKS=2)
module tb_halt_result_checker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [0:0]  cfg_idx = '0;
    logic [7:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        busy, done, pass, timeout;
    logic [1:0]  fail_count;
    logic [0:0]  first_fail_idx;
    logic [15:0] first_fail_data;

    typedef struct packed {
        logic        pass;
        logic [1:0]  fc;
        logic        ffi;
        logic [15:0] ffd;
        logic        to;
    } res_t;

    logic [15:0] mem [256];
    logic [7:0]  exp_addr [$];
    res_t        exp_res [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_count = 0;
    int          exp_rd_total = 0;
    int          k;
    logic        done_prev = 1'b0;

    halt_result_checker #(
        .DATA_W(16), .ADDR_W(8), .NUM_CHECKS(2), .TIMEOUT_W(24), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .halt(halt),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_idx(first_fail_idx), .first_fail_data(first_fail_data),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_reads();
        exp_addr.push_back(8'h14);
        exp_addr.push_back(8'h0F);
        exp_rd_total += 2;
    endtask

    task automatic push_res(input logic p, input logic [1:0] fc, input logic ffi, input logic [15:0] ffd, input logic to);
        res_t r;
        r.pass = p;
        r.fc = fc;
        r.ffi = ffi;
        r.ffd = ffd;
        r.to = to;
        exp_res.push_back(r);
    endtask

    task automatic cfg(input logic i, input logic [7:0] a, input logic [15:0] d);
        cfg_we = 1'b1;
        cfg_idx = i;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
        chk({tag, "_addr"}, {24'd0, mem_addr}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
        chk({tag, "_fc"}, {30'd0, fail_count}, 32'd0);
        chk({tag, "_ffi"}, {31'd0, first_fail_idx}, 32'd0);
        chk({tag, "_ffd"}, {16'd0, first_fail_data}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    endtask

    // Scoreboard: pop expected read addresses on each strobe and expected results when done rises
    always @(negedge clk) begin
        res_t r;
        if (mem_rd_en) begin
            rd_count++;
            checks++;
            assert (exp_addr.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_read observed=%0h expected=none", mem_addr);
            end
            if (exp_addr.size() != 0) chk("read_addr", {24'd0, mem_addr}, {24'd0, exp_addr.pop_front()});
        end
        if (done && !done_prev) begin
            checks++;
            assert (exp_res.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_done observed=1 expected=0");
            end
            if (exp_res.size() != 0) begin
                r = exp_res.pop_front();
                chk("pass", {31'd0, pass}, {31'd0, r.pass});
                chk("fail_count", {30'd0, fail_count}, {30'd0, r.fc});
                chk("first_fail_idx", {31'd0, first_fail_idx}, {31'd0, r.ffi});
                chk("first_fail_data", {16'd0, first_fail_data}, {16'd0, r.ffd});
                chk("timeout", {31'd0, timeout}, {31'd0, r.to});
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
        done_prev <= done;
    end

    initial begin
        foreach (mem[i]) mem[i] = '0;
        mem[8'h14] = 16'd850;
        mem[8'h0F] = 16'd4;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        cfg(1'b0, 8'h14, 16'd850);
        cfg(1'b1, 8'h0F, 16'd4);

        // Correct memory, halt at cycle 100
        while (cyc < 70) @(negedge clk);
        push_reads();
        push_res(1'b1, 2'd0, 1'b0, 16'd0, 1'b0);
        start_pulse();
        chk("armed_busy", {31'd0, busy}, 32'd1);
        while (cyc < 100) @(negedge clk);
        chk("armed_wait_busy", {31'd0, busy}, 32'd1);
        halt = 1'b1;
        wait_done(20, k);
        chk("s1_latency", k, 32'd5);
        @(negedge clk);
        chk("s1_done_held", {31'd0, done}, 32'd1);

        // Bad word at 0x14, then rerun from DONE with it repaired
        mem[8'h14] = 16'd0;
        push_reads();
        push_res(1'b0, 2'd1, 1'b0, 16'd0, 1'b0);
        start_pulse();
        wait_done(20, k);
        chk("s2_latency", k, 32'd5);
        mem[8'h14] = 16'd850;
        push_reads();
        push_res(1'b1, 2'd0, 1'b0, 16'd0, 1'b0);
        start_pulse();
        chk("s2_cleared_fc", {30'd0, fail_count}, 32'd0);
        chk("s2_cleared_done", {31'd0, done}, 32'd0);
        wait_done(20, k);
        chk("s2b_latency", k, 32'd5);

        // Halt already high at start; table write while ARMED must be dropped
        push_reads();
        push_res(1'b1, 2'd0, 1'b0, 16'd0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg(1'b1, 8'h0F, 16'd5);
        wait_done(20, k);
        chk("s3_latency", k, 32'd4);

        // Reset in COMPARE of entry 1, then rerun against the cleared table
        push_reads();
        start_pulse();
        repeat (4) @(negedge clk);
        chk("s4_in_compare_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("s4_reset");
        reset = 1'b0;
        push_res(1'b1, 2'd0, 1'b0, 16'd0, 1'b0);
        start_pulse();
        wait_done(20, k);
        chk("s4_empty_latency", k, 32'd3);

        // Halt never comes
        halt = 1'b0;
        @(negedge clk);
`ifdef HALT_CHECKER_TIMEOUT_EN
        push_res(1'b0, 2'd0, 1'b0, 16'd0, 1'b1);
        start_pulse();
        wait_done(100, k);
        chk("s5_timeout_latency", k, 32'd50);
        chk("s5_timeout_flag", {31'd0, timeout}, 32'd1);
`else
        start_pulse();
        repeat (1000) @(negedge clk);
        chk("s5_still_busy", {31'd0, busy}, 32'd1);
        chk("s5_no_done", {31'd0, done}, 32'd0);
        chk("s5_no_timeout", {31'd0, timeout}, 32'd0);
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("left_reads", exp_addr.size(), 32'd0);
        chk("left_results", exp_res.size(), 32'd0);
        chk("read_total", rd_count, exp_rd_total);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
